// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - shared data-memory bus bundle (req/gnt + rvalid)
//
// Purpose: groups the signals between one core's DMEM access controller and
// the shared multi-core data-memory arbiter.
// Ports (signals):
//   bus_req    controller -> arbiter  access request
//   bus_we     controller -> arbiter  1 = write, 0 = read (valid with bus_req)
//   bus_addr   controller -> arbiter  word-aligned address (valid with bus_req)
//   bus_wdata  controller -> arbiter  store data (valid with bus_req & bus_we)
//   bus_gnt    arbiter -> controller  grant, accepted when bus_req & bus_gnt
//   bus_rvalid arbiter -> controller  read data valid
//   bus_rdata  arbiter -> controller  read data
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access controller with timeout
//
// Purpose: takes the registered DMEM request of the MEM stage, runs it on the
// shared data-memory bus, stalls the pipeline while it is outstanding and
// returns load data to writeback. Misaligned, illegal (load+store) and
// timed-out accesses raise a one-cycle error pulse.
// Ports:
//   clk, rst_n             core clock, asynchronous active-low reset
//   mem_address_in         access address from the MEM stage
//   mem_write_data_in      store data from the MEM stage
//   mem_read_en_in         load request
//   mem_write_en_in        store request
//   bus                    shared DMEM bus (master modport)
//   stall_out              combinational pipeline freeze
//   read_data_out          load result (holds between loads)
//   read_data_valid_out    one-cycle pulse per completed load
//   access_err_out         one-cycle pulse per failed access
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_address_in,
  input  logic [31:0]           mem_write_data_in,
  input  logic                  mem_read_en_in,
  input  logic                  mem_write_en_in,
  dmem_access_ctrl_if.master    bus,
  output logic                  stall_out,
  output logic [31:0]           read_data_out,
  output logic                  read_data_valid_out,
  output logic                  access_err_out
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  // A width of at least one keeps the counter legal when the timeout is disabled.
  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;

  logic req_present;
  logic bad_req;
  logic tmo;

  assign req_present = mem_read_en_in | mem_write_en_in;
  assign bad_req     = (mem_read_en_in & mem_write_en_in) | (mem_address_in[1:0] != 2'b00);

  // cnt_q counts the REQ/RESP cycles already completed, so the cycle in which
  // it equals TIMEOUT_CYCLES-1 is the last one allowed before the abort.
  assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_LAST);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; grant and rvalid take priority over a timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_present) begin
          state_d = bad_req ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          state_d = bus_we_q ? DONE : RESP;
        end else if (tmo) begin
          state_d = DONE;
        end
      end
      RESP: begin
        if (bus.bus_rvalid || tmo) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the counter.
  always_comb begin
    cnt_d       = cnt_q;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_present) begin
          if (bad_req) begin
            err_d = 1'b1;
            if (mem_read_en_in) begin
              rdata_d  = ERR_RDATA;
              rvalid_d = 1'b1;
            end
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write_en_in;
            bus_addr_d  = {mem_address_in[31:2], 2'b00};
            bus_wdata_d = mem_write_data_in;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (!bus.bus_gnt) begin
          if (tmo) begin
            err_d = 1'b1;
            if (!bus_we_q) begin
              rdata_d  = ERR_RDATA;
              rvalid_d = 1'b1;
            end
          end else begin
            bus_req_d = 1'b1;
          end
        end
      end
      RESP: begin
        cnt_d = cnt_inc;
        if (bus.bus_rvalid) begin
          rdata_d  = bus.bus_rdata;
          rvalid_d = 1'b1;
        end else if (tmo) begin
          err_d    = 1'b1;
          rdata_d  = ERR_RDATA;
          rvalid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  assign read_data_out       = rdata_q;
  assign read_data_valid_out = rvalid_q;
  assign access_err_out      = err_q;

  // Gated by rst_n so the pipeline is released as soon as reset asserts.
  assign stall_out = rst_n & ((state_q == REQ) | (state_q == RESP) |
                              ((state_q == IDLE) & req_present));

endmodule
